store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 30 +++
 rtl/store_buffer.sv | 96 +++++++++
 tb/tb_store_buffer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// CPU-side and data-memory-side signals of the store buffer.
// The store buffer takes the slave view; the CPU/memory environment takes the master view.
interface store_buffer_if;
    logic [31:0] Address;
    logic [31:0] Write_Data;
    logic        Mem_Read;
    logic        Mem_Write;
    logic [31:0] Read_Data;
    logic        Stall;
    logic        Empty;
    logic [31:0] mem_Address;
    logic [31:0] mem_Write_Data;
    logic        mem_Mem_Read;
    logic        mem_Mem_Write;
    logic [31:0] mem_Read_Data;

    // Store handshake: Mem_Write (with Mem_Read low) is valid, !Stall is ready;
    // a store is accepted on the rising edge where both hold.
    modport slave (
        input  Address, Write_Data, Mem_Read, Mem_Write, mem_Read_Data,
        output Read_Data, Stall, Empty, mem_Address, mem_Write_Data,
        output mem_Mem_Read, mem_Mem_Write
    );

    modport master (
        output Address, Write_Data, Mem_Read, Mem_Write, mem_Read_Data,
        input  Read_Data, Stall, Empty, mem_Address, mem_Write_Data,
        input  mem_Mem_Read, mem_Mem_Write
    );
endinterface

// File: rtl/store_buffer.sv
// Write buffer between CPU and data memory: stores queue in a FIFO and drain on
// cycles without a load; loads bypass the queue and forward from the youngest match.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [29:0]      idx_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    logic          is_store;
    logic          push;
    logic          pop;
    logic          hit;
    logic [31:0]   fwd_data;
    logic [PW-1:0] slot;

    // A load owns the memory port for the cycle, so it blocks both push and pop.
    assign is_store  = bus.Mem_Write && !bus.Mem_Read;
    assign push      = is_store && (count_q != FULL);
    assign pop       = !bus.Mem_Read && (count_q != '0);
    assign bus.Stall = is_store && (count_q == FULL);
    assign bus.Empty = (count_q == '0);

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + PW'(i);
            if (vld_q[slot] && (idx_q[slot] == bus.Address[31:2])) begin
                hit      = 1'b1;
                fwd_data = data_q[slot];
            end
        end
    end

    always_comb begin
        bus.mem_Address    = '0;
        bus.mem_Write_Data = '0;
        bus.mem_Mem_Read   = 1'b0;
        bus.mem_Mem_Write  = 1'b0;
        bus.Read_Data      = '0;
        if (bus.Mem_Read) begin
            bus.mem_Address  = bus.Address;
            bus.mem_Mem_Read = 1'b1;
            bus.Read_Data    = hit ? fwd_data : bus.mem_Read_Data;
        end else if (count_q != '0) begin
            bus.mem_Address    = {idx_q[head_q], 2'b00};
            bus.mem_Write_Data = data_q[head_q];
            bus.mem_Mem_Write  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PW'(1);
            end
            if (push) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_q[tail_q]  <= bus.Address[31:2];
            data_q[tail_q] <= bus.Write_Data;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed and random checks of store_buffer against a queue-plus-memory reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if sb ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sb)
  );

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  assign sb.mem_Read_Data = mem[sb.mem_Address[11:2]];
  always @(posedge clk) begin
    if (sb.mem_Mem_Write) mem[sb.mem_Address[11:2]] <= sb.mem_Write_Data;
  end

  // Pending stores in acceptance order: {word index, data}.
  logic [61:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] addr);
    logic [31:0] r;
    r = ref_mem[addr[11:2]];
    foreach (exp_q[i]) if (exp_q[i][61:32] == addr[31:2]) r = exp_q[i][31:0];
    return r;
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    sb.Mem_Read   = rd;
    sb.Mem_Write  = wr;
    sb.Address    = addr;
    sb.Write_Data = data;
  endtask

  // One clock: drive at the falling edge, check just after, update model after the rising edge.
  task automatic cycle(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_mr, e_mw, e_stall, e_empty;
    bit          do_pop, do_push;
    drive(rd, wr, addr, data);
    #1;
    e_stall = wr && !rd && (exp_q.size() == DEPTH);
    e_empty = (exp_q.size() == 0);
    do_push = wr && !rd && (exp_q.size() < DEPTH);
    do_pop  = 1'b0;
    e_addr  = '0;
    e_wdata = '0;
    e_rdata = '0;
    e_mr    = 1'b0;
    e_mw    = 1'b0;
    if (rd) begin
      e_mr    = 1'b1;
      e_addr  = addr;
      e_rdata = model_load(addr);
    end else if (exp_q.size() > 0) begin
      e_mw    = 1'b1;
      e_addr  = {exp_q[0][61:32], 2'b00};
      e_wdata = exp_q[0][31:0];
      do_pop  = 1'b1;
    end
    check($sformatf("%s.stall", tag), {31'b0, sb.Stall}, {31'b0, e_stall});
    check($sformatf("%s.empty", tag), {31'b0, sb.Empty}, {31'b0, e_empty});
    check($sformatf("%s.mem_rd", tag), {31'b0, sb.mem_Mem_Read}, {31'b0, e_mr});
    check($sformatf("%s.mem_wr", tag), {31'b0, sb.mem_Mem_Write}, {31'b0, e_mw});
    check($sformatf("%s.mem_addr", tag), sb.mem_Address, e_addr);
    check($sformatf("%s.rdata", tag), sb.Read_Data, e_rdata);
    if (!rd) check($sformatf("%s.mem_wdata", tag), sb.mem_Write_Data, e_wdata);
    @(posedge clk);
    if (do_pop) begin
      ref_mem[exp_q[0][41:32]] = exp_q[0][31:0];
      void'(exp_q.pop_front());
    end
    if (do_push) exp_q.push_back({addr[31:2], data});
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hC0DE_0000 | 32'(i);
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    drive(1'b0, 1'b1, 32'h0000_0040, 32'h5555_5555);
    repeat (2) @(negedge clk);
    check("rst.empty", {31'b0, sb.Empty}, 32'd1);
    check("rst.mem_wr", {31'b0, sb.mem_Mem_Write}, 32'd0);
    rst_n = 1'b1;

    // Out of reset: a load sees memory only.
    cycle("post_rst_load", 1'b1, 1'b0, 32'h0000_07D0, 32'h0);

    cycle("s1_store", 1'b0, 1'b1, 32'h0000_07D0, 32'h11);
    cycle("s1_drain", 1'b0, 1'b0, 32'h0, 32'h0);
    cycle("s1_after", 1'b0, 1'b0, 32'h0, 32'h0);
    check("s1_memword", mem[500], 32'h11);

    cycle("s2_store", 1'b0, 1'b1, 32'h0000_0100, 32'hAA);
    cycle("s2_fwd", 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    cycle("s2_drain", 1'b0, 1'b0, 32'h0, 32'h0);
    check("s2_memword", mem[64], 32'hAA);

    cycle("s3_st1", 1'b0, 1'b1, 32'h0000_0200, 32'd1);
    cycle("s3_st2", 1'b0, 1'b1, 32'h0000_0200, 32'd2);
    cycle("s3_load", 1'b1, 1'b1, 32'h0000_0202, 32'hDEAD);
    cycle("s3_drain1", 1'b0, 1'b0, 32'h0, 32'h0);
    cycle("s3_drain2", 1'b0, 1'b0, 32'h0, 32'h0);
    check("s3_memword", mem[128], 32'd2);

    for (int i = 0; i <= DEPTH; i++)
      cycle($sformatf("s4_st%0d", i), 1'b0, 1'b1, 32'h0000_0180 + 32'(4 * i), 32'h100 + 32'(i));
    cycle("s4_drain", 1'b0, 1'b0, 32'h0, 32'h0);

    // Asynchronous reset while a store is pending.
    cycle("s5_store", 1'b0, 1'b1, 32'h0000_0300, 32'h33);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("s5_pending_wr", {31'b0, sb.mem_Mem_Write}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("s5_rst_empty", {31'b0, sb.Empty}, 32'd1);
    check("s5_rst_mem_wr", {31'b0, sb.mem_Mem_Write}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("s5_load", 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    cycle("s5_idle", 1'b0, 1'b0, 32'h0, 32'h0);
    check("s5_memword", mem[192], 32'hC0DE_00C0);

    for (int n = 0; n < 400; n++) begin
      logic        rd, wr;
      logic [31:0] addr;
      rd   = ($urandom_range(0, 3) == 0);
      wr   = ($urandom_range(0, 1) == 1);
      addr = {20'b0, 10'(64 + $urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      cycle($sformatf("rnd%0d", n), rd, wr, addr, $urandom);
    end
    repeat (2) cycle("final_drain", 1'b0, 1'b0, 32'h0, 32'h0);
    for (int w = 64; w < 80; w++) check($sformatf("final_mem%0d", w), mem[w], ref_mem[w]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
